// File: rtl/maj_tt_scanner.sv
// Sweeps all 128 minterms into a combinational function-under-test, captures its
// truth table and compares it against the EXPECTED signature.
module maj_tt_scanner #(
  parameter logic [127:0] EXPECTED = 128'hfeeaeae8eae8ea88eea8e8a8e8a8a880,
  parameter int unsigned  SETTLE   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         f_in,
  output logic [6:0]   x_out,
  output logic         busy,
  output logic         done,
  output logic [127:0] tt,
  output logic [7:0]   ones,
  output logic         match,
  output logic [7:0]   first_miss
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t       state_q;
  logic [6:0]   idx_q;
  logic [3:0]   settle_cnt_q;
  logic [6:0]   x_out_q;
  logic         busy_q;
  logic         done_q;
  logic [127:0] tt_q;
  logic [7:0]   ones_q;
  logic         match_q;
  logic [7:0]   first_miss_q;

  logic         miss_d;
  logic [7:0]   ones_d;
  logic [6:0]   idx_d;

  assign miss_d = f_in ^ EXPECTED[idx_q];
  assign ones_d = ones_q + {7'd0, f_in};
  assign idx_d  = idx_q + 7'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 7'd0;
      settle_cnt_q <= 4'd0;
      x_out_q      <= 7'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tt_q         <= '0;
      ones_q       <= 8'd0;
      match_q      <= 1'b0;
      first_miss_q <= 8'h80;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= DRIVE;
            busy_q       <= 1'b1;
            idx_q        <= 7'd0;
            settle_cnt_q <= 4'd0;
            x_out_q      <= 7'd0;
            tt_q         <= '0;
            ones_q       <= 8'd0;
            match_q      <= 1'b0;
            first_miss_q <= 8'h80;
          end else begin
            state_q <= IDLE;
          end
        end
        DRIVE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            settle_cnt_q <= 4'd0;
            state_q      <= SAMPLE;
          end else begin
            settle_cnt_q <= settle_cnt_q + 4'd1;
          end
        end
        SAMPLE: begin
          tt_q[idx_q] <= f_in;
          ones_q      <= ones_d;
          if (miss_d && first_miss_q[7])
            first_miss_q <= {1'b0, idx_q};
          if (idx_q == 7'd127) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // Table matches only if no earlier miss and the last minterm agrees.
            match_q <= first_miss_q[7] & ~miss_d;
          end else begin
            idx_q   <= idx_d;
            x_out_q <= idx_d;
            state_q <= DRIVE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x_out      = x_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign tt         = tt_q;
  assign ones       = ones_q;
  assign match      = match_q;
  assign first_miss = first_miss_q;

endmodule

// File: doc/maj_tt_scanner.md
# maj_tt_scanner

Sequential truth-table capture engine for the 7-input majority-network classification blocks. It sweeps all 128 input minterms into a combinational function-under-test (FUT) on `x_out[6:0]`, samples the FUT output `f_in`, and assembles the 128-bit truth table. The table is then checked against a parameterised expected signature. The block sits directly upstream and downstream of a FUT: it drives the FUT's `x0..x6` and consumes its `out`.

## Interface
Parameters:
- `EXPECTED`, default `128'hfeeaeae8eae8ea88eea8e8a8e8a8a880`: reference truth table; bit i = f(minterm i).
- `SETTLE`, default 1: cycles `x_out` is held before sampling; legal range 1..15.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: request a scan; sampled only in IDLE or DONE.
- `f_in`, in, 1: FUT output.
- `x_out`, out, 7: minterm driven to FUT; `x_out[k]` feeds FUT input `xk`.
- `busy`, out, 1: high while a scan is in progress.
- `done`, out, 1: one-cycle pulse when a scan completes.
- `tt`, out, 128: captured truth table; `tt[i]` = f(i).
- `ones`, out, 8: popcount of captured 1s.
- `match`, out, 1: `tt == EXPECTED`; valid from `done` onward.
- `first_miss`, out, 8: lowest index i with `f(i) != EXPECTED[i]`; `8'h80` if none.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE. Internal counters: `idx` (7 bit), `settle_cnt` (4 bit).
- IDLE:
  - `start=1` → DRIVE.
  - Also clears `tt`, `ones`, `match`, `idx`, `settle_cnt`, and sets `first_miss=8'h80`.
- DRIVE:
  - `x_out=idx`.
  - `settle_cnt` increments each cycle.
  - When `settle_cnt==SETTLE-1` → SAMPLE, and `settle_cnt` clears.
- SAMPLE:
  - At the clock edge ending this cycle: `tt[idx] <= f_in`, and `ones <= ones + f_in`.
  - If `f_in != EXPECTED[idx]` and `first_miss[7]==1`, then `first_miss <= {1'b0, idx}`.
  - If `idx==127` → DONE; otherwise `idx <= idx+1` → DRIVE.
- DONE:
  - `done=1` for this cycle only; `match` registered on entry.
  - Next state: IDLE, or DRIVE if `start=1` (same clear actions as in IDLE).
- `start` during DRIVE or SAMPLE is ignored; no queuing.
- `x_out` holds the current `idx` in both DRIVE and SAMPLE, so the FUT input is stable across the sample edge. `x_out` holds its last value in DONE and IDLE.
- `tt`, `ones`, `match` and `first_miss` hold their values after DONE until the next accepted start.
- `ones` never overflows; the maximum value is 128.
- `idx` never wraps during a scan; the transition at 127 exits to DONE.

## Timing
- Reset (`rst_n=0` at an edge), from any state including mid-scan:
  - Next state IDLE.
  - `x_out=0`, `busy=0`, `done=0`, `tt=0`, `ones=0`, `match=0`, `first_miss=8'h80`.
  - An aborted scan leaves no residue.
- Start latency: `start` sampled at edge E0 → `busy=1` and `x_out=0` from the cycle after E0.
- Per minterm: SETTLE cycles in DRIVE plus 1 cycle in SAMPLE = SETTLE+1 cycles.
- `done` pulses in cycle 1 + 128·(SETTLE+1) after E0: cycle 257 for SETTLE=1, cycle 513 for SETTLE=3.
- `busy` is high for exactly 128·(SETTLE+1) cycles, and low in the DONE cycle.
- Back-to-back scans: `start` held high continuously gives consecutive scans with a single DONE cycle between them.
- The FUT must settle combinationally within SETTLE cycles. The block adds no input synchroniser on `f_in`.

## Test plan
- Golden FUT model, SETTLE=1, one `start` pulse:
  - `x_out` steps 0,0,1,1,…,127,127.
  - `done` in cycle 257; `tt=EXPECTED`, `ones=64`, `match=1`, `first_miss=8'h80`.
- FUT model with minterm 5 inverted:
  - `match=0`, `first_miss=8'h05`, `ones=65`.
  - `tt` differs from `EXPECTED` only in bit 5.
- `f_in` tied to 0:
  - `tt=0`, `ones=0`, `match=0`, `first_miss=8'h07` (first 1 in EXPECTED).
- SETTLE=3, golden FUT:
  - Each `x_out` value held 4 cycles; `done` in cycle 513; results identical to the first scenario.
- `start` re-pulsed at cycle 50 of a scan:
  - Ignored; `done` still in cycle 257.
- `start` held high through DONE:
  - Second scan begins the next cycle with `tt` cleared.
- Reset mid-scan:
  - `rst_n=0` for one cycle at cycle 100 → all outputs at reset values next cycle.
  - A subsequent `start` gives a full, correct scan.
